// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, register addresses and default data width
// for the APB slave and its register file.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, READY} state_e;
    localparam logic [1:0] ADDR_REG0 = 2'd0;
    localparam logic [1:0] ADDR_REG1 = 2'd1;
    localparam logic [1:0] ADDR_REG2 = 2'd2;
    localparam logic [1:0] ADDR_CNT  = 2'd3;
    localparam int DATA_W = 8;
endpackage

// File: rtl/apb_regfile.sv
// apb_regfile: three read/write registers plus a read-only counter of
// successful writes; the caller only asserts we_i for addresses 0..2.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int m = DATA_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         we_i,
    input  logic [1:0]   waddr_i,
    input  logic [m-1:0] wdata_i,
    input  logic [1:0]   raddr_i,
    output logic [m-1:0] rdata_o,
    output logic [m-1:0] reg0_o
);
    logic [m-1:0] regs_q [3];
    logic [m-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '{default: '0};
            cnt_q  <= '0;
        end else if (we_i) begin
            for (int i = 0; i < 3; i++)
                if (waddr_i == 2'(i)) regs_q[i] <= wdata_i;
            cnt_q <= cnt_q + m'(1);
        end
    end

    always_comb begin
        rdata_o = raddr_i == ADDR_REG0 ? regs_q[0] :
                  raddr_i == ADDR_REG1 ? regs_q[1] :
                  raddr_i == ADDR_REG2 ? regs_q[2] : cnt_q;
    end

    assign reg0_o = regs_q[0];
endmodule

// File: rtl/apb_slave.sv
// apb_slave: APB completer with a programmable number of wait states,
// four-entry register map and a write-strobe side output for register 0.
module apb_slave
    import apb_pkg::*;
#(
    parameter int m           = DATA_W,
    parameter int WAIT_STATES = 1
) (
    input  logic         PCLK,
    input  logic         PRESET,
    input  logic         PSEL,
    input  logic         PENABLE,
    input  logic         PWRITE,
    input  logic [1:0]   PADDR,
    input  logic [m-1:0] PWDATA,
    output logic         PREADY,
    output logic [m-1:0] PRDATA,
    output logic         PSLVERR,
    output logic [m-1:0] o_data,
    output logic         o_data_valid
);
    localparam logic [1:0] WS_CNT = 2'(WAIT_STATES);

    state_e       state_q, state_d;
    logic [1:0]   wcnt_q, wcnt_d;
    logic [1:0]   addr_q, addr_d;
    logic         write_q, write_d;
    logic [m-1:0] wdata_q, wdata_d;
    logic         ready_q, valid_q, valid_d;
    logic         done, err, we;
    logic [m-1:0] rdata;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            ready_q <= state_d == READY;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        done    = 1'b0;
        case (state_q)
            IDLE: if (PSEL && !PENABLE) begin
                addr_d  = PADDR;
                write_d = PWRITE;
                wdata_d = PWDATA;
                wcnt_d  = WS_CNT;
                state_d = WAIT_STATES == 0 ? READY : WAIT;
            end
            WAIT: if (!PSEL) state_d = IDLE;
            else begin
                wcnt_d  = wcnt_q - 2'd1;
                state_d = wcnt_q == 2'd1 ? READY : WAIT;
            end
            READY: if (!PSEL || PENABLE) begin
                state_d = IDLE;
                done    = PSEL;
            end
            default: state_d = IDLE;
        endcase
    end

    // Commits use the latched transfer, never the live bus.
    assign err     = write_q && addr_q == ADDR_CNT;
    assign we      = done && write_q && !err;
    assign valid_d = we && addr_q == ADDR_REG0;

    apb_regfile #(.m(m)) u_regfile (
        .clk_i   (PCLK),
        .rst_ni  (PRESET),
        .we_i    (we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (addr_q),
        .rdata_o (rdata),
        .reg0_o  (o_data)
    );

    assign PREADY       = ready_q;
    assign PSLVERR      = ready_q && err;
    assign PRDATA       = ready_q && !write_q ? rdata : '0;
    assign o_data_valid = valid_q;
endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: directed checks of three apb_slave instances with
// WAIT_STATES of 0, 1 and 3 sharing one bus apart from PSEL.
module tb_apb_slave;
    logic       PCLK = 1'b0;
    logic       PRESET = 1'b0;
    logic       PENABLE = 1'b0;
    logic       PWRITE = 1'b0;
    logic [1:0] PADDR = '0;
    logic [7:0] PWDATA = '0;
    logic [2:0] psel = '0;
    logic [2:0] pready, pslverr, vld;
    logic [7:0] prdata [3];
    logic [7:0] odata [3];
    int vcnt [3] = '{0, 0, 0};
    int n_tests = 0;
    int n_fail = 0;

    always #5 PCLK = ~PCLK;

    apb_slave #(.m(8), .WAIT_STATES(0)) u_ws0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(pready[0]),
        .PRDATA(prdata[0]), .PSLVERR(pslverr[0]), .o_data(odata[0]),
        .o_data_valid(vld[0]));
    apb_slave #(.m(8), .WAIT_STATES(1)) u_ws1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(pready[1]),
        .PRDATA(prdata[1]), .PSLVERR(pslverr[1]), .o_data(odata[1]),
        .o_data_valid(vld[1]));
    apb_slave #(.m(8), .WAIT_STATES(3)) u_ws3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(pready[2]),
        .PRDATA(prdata[2]), .PSLVERR(pslverr[2]), .o_data(odata[2]),
        .o_data_valid(vld[2]));

    always @(negedge PCLK) for (int i = 0; i < 3; i++) if (vld[i]) vcnt[i]++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives a setup phase now (just after a rising edge), then access until
    // PREADY; returns just after the completion edge with PSEL still high.
    task automatic xfer(input int d, input bit wr, input logic [1:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output bit err, output int n);
        psel = 3'(1 << d); PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        n = 0;
        do begin n++; @(negedge PCLK); end while (!pready[d] && n < 20);
        chk("pready_seen", {31'd0, pready[d]}, 1);
        rd = prdata[d]; err = pslverr[d];
        @(posedge PCLK); #1;
    endtask

    task automatic idle();
        psel = '0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic wr_chk(input int d, input logic [1:0] a, input logic [7:0] wd,
                          input bit exp_err, input int exp_n, input string tag);
        logic [7:0] rd; bit err; int n;
        xfer(d, 1'b1, a, wd, rd, err, n);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_lat"}, n, exp_n);
        idle();
    endtask

    task automatic rd_chk(input int d, input logic [1:0] a, input logic [7:0] exp,
                          input int exp_n, input string tag);
        logic [7:0] rd; bit err; int n;
        xfer(d, 1'b0, a, 8'h00, rd, err, n);
        chk({tag, "_data"}, {24'd0, rd}, {24'd0, exp});
        chk({tag, "_err"}, {31'd0, err}, 0);
        chk({tag, "_lat"}, n, exp_n);
        idle();
    endtask

    initial begin
        logic [7:0] rd; bit err; int n; int v;
        repeat (2) @(posedge PCLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_pready", {31'd0, pready[i]}, 0);
            chk("rst_prdata", {24'd0, prdata[i]}, 0);
            chk("rst_pslverr", {31'd0, pslverr[i]}, 0);
            chk("rst_odata", {24'd0, odata[i]}, 0);
            chk("rst_valid", {31'd0, vld[i]}, 0);
        end
        PRESET = 1'b1;
        @(posedge PCLK); #1;

        // One wait state: write reg0, PREADY in 2nd access cycle.
        xfer(1, 1'b1, 2'd0, 8'hA5, rd, err, n);
        chk("w0_lat", n, 2);
        chk("w0_err", {31'd0, err}, 0);
        chk("w0_valid_now", {31'd0, vld[1]}, 1);
        chk("w0_odata", {24'd0, odata[1]}, 8'hA5);
        idle();
        chk("w0_valid_cnt", vcnt[1], 1);
        chk("w0_valid_off", {31'd0, vld[1]}, 0);
        rd_chk(1, 2'd3, 8'd1, 2, "w0_cnt");

        // Zero wait states, write then back-to-back read.
        xfer(0, 1'b1, 2'd2, 8'h3C, rd, err, n);
        chk("w2_lat", n, 1);
        chk("w2_valid", {31'd0, vld[0]}, 0);
        xfer(0, 1'b0, 2'd2, 8'h00, rd, err, n);
        chk("b2b_data", {24'd0, rd}, 8'h3C);
        chk("b2b_lat", n, 1);
        idle();
        chk("prdata_idle", {24'd0, prdata[0]}, 0);
        chk("w2_valid_cnt", vcnt[0], 0);

        // Write to the read-only counter is an error with no side effects.
        wr_chk(1, 2'd3, 8'hFF, 1'b1, 2, "wcnt");
        chk("pslverr_idle", {31'd0, pslverr[1]}, 0);
        rd_chk(1, 2'd3, 8'd1, 2, "wcnt_cnt");
        rd_chk(1, 2'd0, 8'hA5, 2, "wcnt_r0");
        chk("wcnt_valid_cnt", vcnt[1], 1);

        // Three wait states, transfer aborted after two access cycles.
        psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 2'd1; PWDATA = 8'h11;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK); chk("abort_rdy1", {31'd0, pready[2]}, 0);
        @(posedge PCLK); @(negedge PCLK); chk("abort_rdy2", {31'd0, pready[2]}, 0);
        @(posedge PCLK); #1 psel = '0; PENABLE = 1'b0;
        @(negedge PCLK); chk("abort_rdy3", {31'd0, pready[2]}, 0);
        @(posedge PCLK); #1;
        chk("abort_rdy4", {31'd0, pready[2]}, 0);
        rd_chk(2, 2'd1, 8'h00, 4, "abort_r1");
        rd_chk(2, 2'd3, 8'h00, 4, "abort_cnt");
        wr_chk(2, 2'd1, 8'h22, 1'b0, 4, "post_abort_w");
        rd_chk(2, 2'd1, 8'h22, 4, "post_abort_r");

        // Reset during the wait state of a reg0 write.
        psel = 3'b010; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 2'd0; PWDATA = 8'h77;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        v = vcnt[1];
        #2 PRESET = 1'b0;
        #1;
        chk("mid_rst_pready", {31'd0, pready[1]}, 0);
        chk("mid_rst_prdata", {24'd0, prdata[1]}, 0);
        chk("mid_rst_pslverr", {31'd0, pslverr[1]}, 0);
        chk("mid_rst_odata", {24'd0, odata[1]}, 0);
        chk("mid_rst_valid", {31'd0, vld[1]}, 0);
        psel = '0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("post_rst_odata", {24'd0, odata[1]}, 0);
        chk("post_rst_valid_cnt", vcnt[1], v);
        rd_chk(1, 2'd0, 8'h00, 2, "post_rst_r0");
        wr_chk(1, 2'd0, 8'h5A, 1'b0, 2, "first_w");
        chk("first_w_odata", {24'd0, odata[1]}, 8'h5A);
        chk("first_w_valid_cnt", vcnt[1], v + 1);

        // Counter wrap: 256 back-to-back writes, then one more.
        for (int i = 0; i < 256; i++) xfer(0, 1'b1, 2'd1, 8'(i), rd, err, n);
        idle();
        rd_chk(0, 2'd3, 8'h00, 1, "wrap_cnt");
        rd_chk(0, 2'd1, 8'hFF, 1, "wrap_r1");
        wr_chk(0, 2'd1, 8'h01, 1'b0, 1, "w257");
        rd_chk(0, 2'd3, 8'h01, 1, "w257_cnt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
